// File: rtl/sonar_ping_scheduler.sv
// Sonar ping sequencer: TX burst, ring-down blanking, listen window, hold-off; reports first-echo TOF or timeout.
// Optional macro ECHO_QUALIFY_EN requires QUAL_CYCLES consecutive high listen cycles before an echo is accepted.
module sonar_ping_scheduler #(
  parameter int unsigned BURST_CYCLES   = 25000,
  parameter int unsigned BLANK_CYCLES   = 50000,
  parameter int unsigned LISTEN_CYCLES  = 2000000,
  parameter int unsigned HOLDOFF_CYCLES = 100000,
`ifdef ECHO_QUALIFY_EN
  parameter int unsigned QUAL_CYCLES    = 3,
`endif
  localparam int unsigned TOF_W = $clog2(BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES + 1)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             continuous_in,
  input  logic             abort_in,
  input  logic             echo_in,
  output logic             tx_en_out,
  output logic             busy_out,
  output logic [TOF_W-1:0] tof_out,
  output logic             tof_valid_out,
  output logic             timeout_out
);

  localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TOF_W-1:0]  TX_LAST     = TOF_W'(BURST_CYCLES - 1);
  localparam logic [TOF_W-1:0]  BLANK_LAST  = TOF_W'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [TOF_W-1:0]  LISTEN_LAST = TOF_W'(BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TX, BLANK, LISTEN, HOLDOFF} state_t;

  state_t             state, state_n;
  logic [TOF_W-1:0]   tof_cnt, tof_cnt_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic [TOF_W-1:0]   tof_n;
  logic               valid_n, timeout_n;
  logic               echo_hit;
  logic [TOF_W-1:0]   hit_tof;

`ifdef ECHO_QUALIFY_EN
  localparam int unsigned QUAL_W = $clog2(QUAL_CYCLES + 1);
  logic [QUAL_W-1:0] qual_cnt, qual_cnt_n;
  logic [TOF_W-1:0]  run_start, run_start_n;

  // Run-length qualifier; the run counter only advances on LISTEN cycles.
  always_comb begin
    qual_cnt_n  = '0;
    run_start_n = run_start;
    echo_hit    = 1'b0;
    hit_tof     = tof_cnt;
    if (state == LISTEN && echo_in) begin
      if (qual_cnt == '0) run_start_n = tof_cnt;
      else                hit_tof     = run_start;
      if (qual_cnt == QUAL_W'(QUAL_CYCLES - 1)) echo_hit   = 1'b1;
      else                                      qual_cnt_n = qual_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      qual_cnt  <= '0;
      run_start <= '0;
    end else begin
      qual_cnt  <= qual_cnt_n;
      run_start <= run_start_n;
    end
  end
`else
  assign echo_hit = (state == LISTEN) && echo_in;
  assign hit_tof  = tof_cnt;
`endif

  // Next-state, counter and result logic; abort overrides everything.
  always_comb begin
    state_n    = state;
    tof_cnt_n  = tof_cnt;
    hold_cnt_n = hold_cnt;
    tof_n      = tof_out;
    valid_n    = 1'b0;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_n   = TX;
          tof_cnt_n = '0;
        end
      end
      TX: begin
        tof_cnt_n = tof_cnt + 1'b1;
        if (tof_cnt == TX_LAST) state_n = BLANK;
      end
      BLANK: begin
        tof_cnt_n = tof_cnt + 1'b1;
        if (tof_cnt == BLANK_LAST) state_n = LISTEN;
      end
      LISTEN: begin
        if (echo_hit) begin
          state_n    = HOLDOFF;
          hold_cnt_n = '0;
          tof_n      = hit_tof;
          valid_n    = 1'b1;
        end else if (tof_cnt == LISTEN_LAST) begin
          state_n    = HOLDOFF;
          hold_cnt_n = '0;
          tof_n      = '1;
          timeout_n  = 1'b1;
        end else begin
          tof_cnt_n = tof_cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) begin
          if (continuous_in) begin
            state_n   = TX;
            tof_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort_in && state != IDLE) begin
      state_n   = IDLE;
      tof_n     = tof_out;
      valid_n   = 1'b0;
      timeout_n = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      tof_cnt       <= '0;
      hold_cnt      <= '0;
      tof_out       <= '0;
      tof_valid_out <= 1'b0;
      timeout_out   <= 1'b0;
      tx_en_out     <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      state         <= state_n;
      tof_cnt       <= tof_cnt_n;
      hold_cnt      <= hold_cnt_n;
      tof_out       <= tof_n;
      tof_valid_out <= valid_n;
      timeout_out   <= timeout_n;
      tx_en_out     <= (state_n == TX);
      busy_out      <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/sonar_ping_scheduler.md
Name: sonar_ping_scheduler

Overview:
- Sequences one sonar ping cycle in this order: transmit burst, ring-down blanking, listen window, hold-off.
- Timestamps the first echo relative to the start of transmit. This is the controller that gates the burst generator and times the receive path.
- Sits between the top-level control logic (start, continuous mode, abort) and the transmit gate plus the synchronized echo-detect strobe.
- Reports the time-of-flight (TOF) in clock cycles, or a timeout.

Parameters:
- BURST_CYCLES, 25000, cycles tx_en_out is held high (10 periods of 40 kHz at 100 MHz).
- BLANK_CYCLES, 50000, cycles after the burst during which echo_in is ignored.
- LISTEN_CYCLES, 2000000, cycles during which echo_in is accepted.
- HOLDOFF_CYCLES, 100000, dead time after a result before the next ping or return to idle.
- QUAL_CYCLES, 3, consecutive-high echo cycles needed to accept an echo. Used only with ECHO_QUALIFY_EN.
- TOF_W, derived, equals $clog2(BURST_CYCLES+BLANK_CYCLES+LISTEN_CYCLES+1). Not user-overridden.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  single-cycle request to begin a ping. Honoured only in IDLE.
- continuous_in  input  1  level. When high, HOLDOFF is followed by a new ping instead of IDLE.
- abort_in  input  1  synchronous abort. Takes effect from any state.
- echo_in  input  1  echo-detect strobe/level, already synchronized to clk_in
- tx_en_out  output  1  transmit burst gate
- busy_out  output  1  high in every state except IDLE
- tof_out  output  TOF_W  last result. Holds until overwritten.
- tof_valid_out  output  1  one-cycle pulse when a new echo result is written to tof_out
- timeout_out  output  1  one-cycle pulse when the listen window expires with no echo

Behaviour:
- Reset (async assert, sync release): state IDLE. tx_en_out, busy_out, tof_valid_out and timeout_out are 0. tof_out is 0. All counters are 0.
- States: IDLE, TX, BLANK, LISTEN, HOLDOFF. All outputs are registered.
- IDLE: start_in=1 moves to TX at the next edge. start_in is ignored in all other states, with no queuing.
- Time reference: t0 is the first cycle with state=TX. At t0, tof_cnt=0, and tof_cnt increments by 1 every cycle from then until the result is taken.
- TX: tx_en_out=1 exactly while state=TX, i.e. for tof_cnt in 0..BURST_CYCLES-1. The next state is BLANK.
- BLANK: tof_cnt runs from BURST_CYCLES to BURST_CYCLES+BLANK_CYCLES-1. echo_in is ignored. The next state is LISTEN.
- LISTEN: tof_cnt runs from B+K to B+K+L-1, where B=BURST_CYCLES, K=BLANK_CYCLES, L=LISTEN_CYCLES.
  - echo_in=1 sampled at tof_cnt=n: at the next edge, tof_out<=n, tof_valid_out pulses for 1 cycle, and the state becomes HOLDOFF.
  - No echo by tof_cnt=B+K+L-1: at the next edge, tof_out<=all-ones (sentinel, always greater than any valid TOF), timeout_out pulses for 1 cycle, and the state becomes HOLDOFF.
  - If echo_in=1 on the final listen cycle, the echo wins and there is no timeout.
- Only the first echo per ping is reported. Later echoes are ignored.
- HOLDOFF lasts exactly HOLDOFF_CYCLES cycles. On exit:
  - continuous_in=1, sampled on the last holdoff cycle: go to TX, and tof_cnt restarts at 0.
  - otherwise: go to IDLE.
- abort_in=1 in any non-IDLE state: at the next edge the state is IDLE, tx_en_out=0 and busy_out=0.
  - No tof_valid_out or timeout_out pulse is produced.
  - tof_out is unchanged.
  - abort_in has priority over every other transition, including an echo in the same cycle.
- Reset asserted mid-ping clears everything immediately (async), including tx_en_out.
- Counters saturate by construction: the state transitions bound them, so they never wrap.

Optional Feature:
- Macro: ECHO_QUALIFY_EN.
- Defined: in LISTEN, an echo is accepted only after echo_in has been high for QUAL_CYCLES consecutive LISTEN cycles.
  - The run counter clears on any low cycle and is held at 0 outside LISTEN, so high cycles during BLANK do not count.
  - tof_out reports the tof_cnt of the first cycle of the qualifying run.
  - tof_valid_out pulses at the edge after the QUAL_CYCLES-th high cycle.
  - A run still unqualified at the end of the listen window results in a timeout.
- Not defined: a single-cycle echo_in is accepted as described in Behaviour. QUAL_CYCLES is unused.

Test Plan (B=4, K=3, L=10, H=2):
- start_in pulse, echo_in high at tof_cnt=9 -> tx_en_out high 4 cycles starting at t0; tof_out=9 with tof_valid_out 1 cycle; busy_out low 2 cycles after that, state back in IDLE.
- echo_in high during tof_cnt 4..6 only -> ignored; timeout_out pulses after tof_cnt=16; tof_out=all-ones (31, TOF_W=5).
- echo_in high at tof_cnt=16 (last listen cycle) -> tof_out=16, tof_valid_out=1, timeout_out stays 0.
- continuous_in=1, echoes at 8 then 12 in consecutive pings -> second TX begins exactly 2 cycles after the first result; results are 8 then 12; start_in pulses during busy have no effect.
- abort_in at tof_cnt=2, then abort_in at tof_cnt=10 with echo_in=1 in the same cycle -> both abort to IDLE next edge; tx_en_out drops; no valid/timeout pulse; tof_out unchanged.
- ECHO_QUALIFY_EN, QUAL_CYCLES=3: echo high at 8,9 then low, then high 11..13 -> tof_out=11, valid pulse after cycle 13; rst_n_in low mid-TX clears tx_en_out asynchronously.
